// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : ALU control codes, legality check and the arbiter state
//                encoding shared by the ALU and the ALU share arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // ALU control codes: bit 3 selects the alternate form (SUB / SRA)
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // Arbiter states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // True when the code is one of the ten operations the ALU implements
    function automatic bit alu_ctrl_legal(input logic [3:0] ctrl);
        case (ctrl)
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
            ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Combinational integer ALU (add/sub, shifts, compares,
//                logic ops) with a zero flag on the result.
//  Revision    : 1.0  initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero
);

    localparam int SHW = $clog2(DATA_W);

    logic [SHW-1:0] w_shamt;
    assign w_shamt = op2[SHW-1:0];

    // Operation select; undefined codes produce zero
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_result = op1 + op2;
            ALU_SUB:  alu_result = op1 - op2;
            ALU_SLL:  alu_result = op1 << w_shamt;
            ALU_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_SLTU: alu_result = {{(DATA_W-1){1'b0}}, (op1 < op2)};
            ALU_XOR:  alu_result = op1 ^ op2;
            ALU_SRL:  alu_result = op1 >> w_shamt;
            ALU_SRA:  alu_result = DATA_W'($signed(op1) >>> w_shamt);
            ALU_OR:   alu_result = op1 | op2;
            ALU_AND:  alu_result = op1 & op2;
            default:  alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

endmodule : alu
`default_nettype wire

// File: rtl/alu_share_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches the request
//                vector starting at ptr and wrapping, returns the first hit
//                as a one-hot grant plus its index.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     gnt_id_o,
    output logic               gnt_valid_o
);

    // First requester at or after ptr (modulo NUM_REQ) wins
    always_comb begin
        gnt_o       = '0;
        gnt_id_o    = '0;
        gnt_valid_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(ptr_i) + i) % NUM_REQ;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_o[idx]  = 1'b1;
                gnt_id_o    = IDW'(idx);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Shares one ALU between NUM_REQ requesters. Round-robin
//                grant in IDLE, registered operands in EXEC, held response
//                in RESP until the owner accepts it. One op in flight.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*4-1:0]      req_ctrl,
    input  logic [NUM_REQ*DATA_W-1:0] req_op1,
    input  logic [NUM_REQ*DATA_W-1:0] req_op2,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_zero,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [IDW-1:0]            grant_id
);

    arb_state_t          state_q;
    logic [IDW-1:0]      ptr_q;
    logic [IDW-1:0]      ptr_d;
    logic [IDW-1:0]      grant_id_q;
    logic [3:0]          ctrl_q;
    logic [DATA_W-1:0]   op1_q;
    logic [DATA_W-1:0]   op2_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0]   rsp_result_q;
    logic                rsp_zero_q;
    logic                rsp_err_q;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [IDW-1:0]      w_gnt_id;
    logic                w_gnt_valid;
    logic [DATA_W-1:0]   w_alu_result;
    logic                w_alu_zero;
    logic [NUM_REQ-1:0]  w_owner_onehot;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_arbiter (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .gnt_o       (w_gnt),
        .gnt_id_o    (w_gnt_id),
        .gnt_valid_o (w_gnt_valid)
    );

    // The ALU only ever sees the registered operands of the accepted op
    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .alu_ctrl   (ctrl_q),
        .op1        (op1_q),
        .op2        (op2_q),
        .alu_result (w_alu_result),
        .zero       (w_alu_zero)
    );

    // Accept is only offered while idle, and only to the round-robin winner
    assign req_ready = (state_q == ST_IDLE) ? w_gnt : '0;

    // Next pointer starts the search just after the owner that finished
    assign ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    assign w_owner_onehot = NUM_REQ'(1) << grant_id_q;

    // Issue / execute / respond sequencing with registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            grant_id_q   <= '0;
            ctrl_q       <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        ctrl_q     <= req_ctrl[w_gnt_id*4 +: 4];
                        op1_q      <= req_op1[w_gnt_id*DATA_W +: DATA_W];
                        op2_q      <= req_op2[w_gnt_id*DATA_W +: DATA_W];
                        grant_id_q <= w_gnt_id;
                        state_q    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Illegal codes report an error and a forced zero result
                    if (alu_ctrl_legal(ctrl_q)) begin
                        rsp_result_q <= w_alu_result;
                        rsp_zero_q   <= w_alu_zero;
                        rsp_err_q    <= 1'b0;
                    end else begin
                        rsp_result_q <= '0;
                        rsp_zero_q   <= 1'b1;
                        rsp_err_q    <= 1'b1;
                    end
                    rsp_valid_q <= w_owner_onehot;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    // Only the owner's ready line can retire the response
                    if (rsp_ready[grant_id_q]) begin
                        rsp_valid_q <= '0;
                        ptr_q       <= ptr_d;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= '0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != ST_IDLE);
    assign grant_id   = grant_id_q;

endmodule : alu_share_arbiter
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Directed self-checking bench for alu_share_arbiter with two
//                requesters and hand-computed expected results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;
    localparam int IDW     = 1;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*4-1:0]      req_ctrl;
    logic [NUM_REQ*DATA_W-1:0] req_op1;
    logic [NUM_REQ*DATA_W-1:0] req_op2;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_zero;
    logic                      rsp_err;
    logic                      busy;
    logic [IDW-1:0]            grant_id;

    int n_total = 0;
    int n_pass  = 0;

    alu_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .IDW     (IDW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ctrl   (req_ctrl),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Advance one clock and land just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic v, input logic [3:0] c,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[idx]            = v;
        req_ctrl[idx*4 +: 4]      = c;
        req_op1[idx*DATA_W +: DATA_W] = a;
        req_op2[idx*DATA_W +: DATA_W] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Single requester op with rsp_ready high; checks latency and response
    task automatic run_op(input string tag, input int idx, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_z, input logic exp_e);
        int n;
        rsp_ready = '1;
        set_req(idx, 1'b1, c, a, b);
        #1;
        n = 0;
        while (!req_ready[idx] && n < 20) begin
            tick();
            n++;
        end
        check_val({tag, "_rdy"}, 32'(req_ready), 32'(1 << idx));
        tick();
        req_valid[idx] = 1'b0;
        #1;
        check_val({tag, "_exec_rv"}, 32'(rsp_valid), 32'd0);
        tick();
        check_val({tag, "_rv"},  32'(rsp_valid), 32'(1 << idx));
        check_val({tag, "_res"}, rsp_result, exp_res);
        check_val({tag, "_z"},   32'(rsp_zero), 32'(exp_z));
        check_val({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
        check_val({tag, "_gid"}, 32'(grant_id), 32'(idx));
        tick();
        check_val({tag, "_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_ctrl  = '0;
        req_op1   = '0;
        req_op2   = '0;
        rsp_ready = '0;

        // Reset state
        do_reset();
        check_val("rst_rv",   32'(rsp_valid), 32'd0);
        check_val("rst_res",  rsp_result, 32'd0);
        check_val("rst_z",    32'(rsp_zero), 32'd0);
        check_val("rst_err",  32'(rsp_err), 32'd0);
        check_val("rst_gid",  32'(grant_id), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_rdy",  32'(req_ready), 32'd0);

        // ADD 3+3 from requester 0, then SUB 3-3 from requester 1
        run_op("add", 0, 4'b0000, 32'd3, 32'd3, 32'd6, 1'b0, 1'b0);
        run_op("sub", 1, 4'b1000, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);

        // Simultaneous requests right after reset
        do_reset();
        rsp_ready = '1;
        set_req(0, 1'b1, 4'b0010, 32'hFFFF_FFFD, 32'd4);
        set_req(1, 1'b1, 4'b0011, 32'hFFFF_FFFD, 32'd1);
        #1;
        check_val("sim_rdy0", 32'(req_ready), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        #1;
        check_val("sim_exec_rdy", 32'(req_ready), 32'h0);
        check_val("sim_busy", 32'(busy), 32'h1);
        tick();
        check_val("sim_rv0", 32'(rsp_valid), 32'h1);
        check_val("slt_res", rsp_result, 32'd1);
        tick();
        check_val("sim_rdy1", 32'(req_ready), 32'h2);
        tick();
        req_valid[1] = 1'b0;
        #1;
        tick();
        check_val("sim_rv1", 32'(rsp_valid), 32'h2);
        check_val("sltu_res", rsp_result, 32'd0);
        check_val("sltu_z", 32'(rsp_zero), 32'd1);
        tick();

        // Pointer back at 0; SRA held response with requester 1 waiting
        rsp_ready = 2'b10;
        set_req(0, 1'b1, 4'b1101, 32'hFFFF_FFFE, 32'd1);
        set_req(1, 1'b1, 4'b0000, 32'd1, 32'd2);
        #1;
        check_val("ptr0_rdy", 32'(req_ready), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        #1;
        tick();
        check_val("sra_res", rsp_result, 32'hFFFF_FFFF);
        for (int k = 0; k < 5; k++) begin
            check_val($sformatf("hold%0d_rv", k), 32'(rsp_valid), 32'h1);
            check_val($sformatf("hold%0d_res", k), rsp_result, 32'hFFFF_FFFF);
            check_val($sformatf("hold%0d_rdy", k), 32'(req_ready), 32'h0);
            tick();
        end
        rsp_ready = 2'b11;
        #1;
        check_val("hs_rdy", 32'(req_ready), 32'h0);
        tick();
        check_val("post_rv", 32'(rsp_valid), 32'h0);
        check_val("next_rdy1", 32'(req_ready), 32'h2);
        tick();
        req_valid[1] = 1'b0;
        #1;
        tick();
        check_val("r1_rv", 32'(rsp_valid), 32'h2);
        check_val("r1_res", rsp_result, 32'd3);
        check_val("r1_gid", 32'(grant_id), 32'd1);
        tick();

        // Illegal code, then a legal op clears the error
        run_op("ill",  0, 4'b1001, 32'd5, 32'd7, 32'd0,  1'b1, 1'b1);
        run_op("leg",  0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);

        // Reset during EXEC drops the transaction
        rsp_ready = '1;
        set_req(1, 1'b1, 4'b0110, 32'd1, 32'd2);
        #1;
        check_val("rx_rdy", 32'(req_ready), 32'h2);
        tick();
        req_valid[1] = 1'b0;
        check_val("rx_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_val("rx_idle", 32'(busy), 32'd0);
        check_val("rx_rv",   32'(rsp_valid), 32'd0);
        check_val("rx_res",  rsp_result, 32'd0);
        check_val("rx_gid",  32'(grant_id), 32'd0);
        tick();
        tick();
        check_val("rx_norsp", 32'(rsp_valid), 32'd0);
        set_req(0, 1'b1, 4'b0000, 32'd0, 32'd0);
        set_req(1, 1'b1, 4'b0000, 32'd0, 32'd0);
        #1;
        check_val("rx_ptr0", 32'(req_ready), 32'h1);
        req_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule : tb_alu_share_arbiter
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational `alu` datapath between NUM_REQ requesters (fetch/branch unit, execute unit, debug port) using valid/ready handshakes.
- Round-robin arbitration with a registered issue stage and a held response. One operation is in flight at a time.
- Instantiates the existing `alu` internally; it is the only consumer of that instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_W, 32, operand/result width; must match `alu`.
- IDW, $clog2(NUM_REQ) (min 1), grant index width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_ready  output  NUM_REQ  one-hot accept; high only for the granted requester in IDLE.
- req_ctrl  input  NUM_REQ x 4  alu_ctrl code per requester.
- req_op1  input  NUM_REQ x DATA_W  first operand per requester.
- req_op2  input  NUM_REQ x DATA_W  second operand per requester.
- rsp_valid  output  NUM_REQ  one-hot response valid to the owning requester.
- rsp_ready  input  NUM_REQ  per-requester response accept.
- rsp_result  output  DATA_W  registered ALU result (shared bus).
- rsp_zero  output  1  registered zero flag.
- rsp_err  output  1  high when the accepted ctrl code is illegal.
- busy  output  1  high in EXEC and RESP.
- grant_id  output  IDW  index of the current/last owner.

Behaviour:
- Reset (synchronous, dominates all other events):
  - Outputs: state=IDLE, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, grant_id=0.
  - Internal: rr pointer ptr=0, operand registers cleared.
  - In-flight transaction is dropped; no response is issued.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant g is the first index with req_valid set, searching ptr, ptr+1, … (mod NUM_REQ).
  - req_ready[g]=1 combinationally; transfer occurs on req_valid[g] && req_ready[g].
  - On transfer, latch req_ctrl[g], req_op1[g], req_op2[g] and set grant_id=g. Next state EXEC.
  - No valid requester: stay in IDLE, all req_ready=0.
- EXEC:
  - The `alu` sees the registered operands.
  - At the clock edge, capture alu_result into rsp_result and zero into rsp_zero.
  - Set rsp_valid[grant_id]=1. Next state RESP.
- Illegal codes:
  - Legal set: 0000, 1000, 0001, 0010, 0011, 0100, 0101, 1101, 0110, 0111.
  - Any other code captures rsp_result=0, rsp_zero=1, rsp_err=1.
  - For legal codes, rsp_err=0.
- RESP:
  - rsp_result, rsp_zero and rsp_err hold stable while rsp_valid is high.
  - When rsp_ready[grant_id] is high: clear rsp_valid, set ptr=(grant_id+1) mod NUM_REQ, next state IDLE.
  - rsp_ready on non-owner lines is ignored.
  - No new request is accepted in the same cycle as the response handshake.
- Timing:
  - Latency: accept at cycle t, rsp_valid high at t+2.
  - Minimum issue interval: 3 cycles.
- req_ready is 0 for every requester outside IDLE.
- Requester obligations:
  - Hold ctrl/operands stable while valid is high and not yet accepted.
  - Dropping valid before the grant is legal and has no side effect.
- Simultaneous requests: resolved by the rr pointer only; no requester waits more than NUM_REQ-1 transactions.
- Arithmetic: all width and sign semantics are owned by `alu`. This block performs no arithmetic except the zero-override on illegal codes.

Decomposition:
- alu_pkg holds:
  - localparams for the ten ctrl codes (ALU_ADD=4'b0000, ALU_SUB=4'b1000, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA=4'b1101, ALU_OR, ALU_AND).
  - function alu_ctrl_legal(4-bit) returning bit.
  - the arbiter state enum.
- One sub-module, rr_arbiter:
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant and its index.
  - Purely combinational.
- The `alu` is instantiated unchanged.

Test Plan:
- Requester 0 sends ADD op1=3 op2=3, rsp_ready=1 -> req_ready[0] at t, rsp_valid[0] at t+2, rsp_result=6, rsp_zero=0, rsp_err=0.
- Requester 1 sends SUB 3,3 -> rsp_valid[1], result=0, zero=1.
- Immediately after reset, both valid: req0 SLT op1=-3 op2=4, req1 SLTU op1=-3 op2=1.
  - req0 is granted first with result=1.
  - req1 follows with result=0, and its accept comes 3 cycles after req0's.
  - ptr returns to 0.
- req0 sends SRA op1=0xFFFFFFFE op2=1 with rsp_ready[0] held low 5 cycles while req1 is valid.
  - rsp_result holds 0xFFFFFFFF.
  - req_ready[1] stays 0 until the handshake.
  - req1 is granted next.
- Illegal ctrl 4'b1001 op1=5 op2=7 -> rsp_err=1, result=0, zero=1, and the next legal op clears err.
- reset asserted during EXEC -> next cycle IDLE, all rsp_valid=0, result=0, no response delivered, and ptr=0 on the following arbitration.
